// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache types: refill FSM states, line geometry, beat-counter sizing
package cache_pkg;

    // Bytes per memory word and per default cache line (4 words of 32 bits).
    localparam int WORD_BYTES = 4;
    localparam int LINE_BYTES = 4 * WORD_BYTES;

    // Refill responder states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        WACK  = 2'd3
    } refill_state_e;

    // Width of a counter that indexes every word of a line.
    function automatic int beat_cnt_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/refill_ram.sv
// rtl/refill_ram.sv - backing word store, synchronous write, asynchronous read
// Ports:
//   clk      : clock, writes on rising edge
//   we_i     : write enable
//   waddr_i  : word write address
//   wdata_i  : write data
//   raddr_i  : word read address
//   rdata_o  : combinational read data
// Contents are not reset.
module refill_ram #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cache_refill_responder.sv
// rtl/cache_refill_responder.sv - memory-side responder for cache line refills and write-through
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   req_valid_i     : request present          req_ready_o : request accepted (IDLE only)
//   req_write_i     : 1 = word write, 0 = line refill
//   req_addr_i      : byte address             req_wdata_i : write data
//   rsp_valid_o     : response beat valid      rsp_ready_i : beat taken
//   rsp_data_o      : refill word (0 on write ack)
//   rsp_last_o      : final beat of transaction
//   busy_o          : transaction in flight
module cache_refill_responder
    import cache_pkg::*;
#(
    parameter int DW             = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_LATENCY    = 2,
    parameter int MEM_AW         = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_write_i,
    input  logic [DW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_data_o,
    output logic          rsp_last_o,
    output logic          busy_o
);

    localparam int            BW        = beat_cnt_w(WORDS_PER_LINE);
    localparam logic [3:0]    LAT       = 4'(MEM_LATENCY);
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_LINE - 1);
    localparam logic [DW-1:0] LINE_MASK = DW'(WORDS_PER_LINE * WORD_BYTES - 1);

    refill_state_e state_q, state_d;
    logic [3:0]    lat_q, lat_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          write_q, write_d;

    logic              rsp_hs;
    logic              ram_we;
    logic [DW-1:0]     line_base;
    logic [MEM_AW-1:0] ram_waddr;
    logic [MEM_AW-1:0] ram_raddr;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata;
    logic              unused_addr_bits;

    // Line base is aligned, so OR-ing the beat number into the word index
    // walks the line without an adder.
    assign line_base = addr_q & ~LINE_MASK;
    assign ram_raddr = line_base[MEM_AW+1:2] | MEM_AW'(beat_q);

    // With zero latency the commit happens on the accept edge itself, so the
    // write port must take the request inputs directly while still in IDLE.
    assign ram_waddr = (state_q == IDLE) ? req_addr_i[MEM_AW+1:2] : addr_q[MEM_AW+1:2];
    assign ram_wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;

    assign unused_addr_bits = ^{addr_q, req_addr_i};

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        ram_we  = 1'b0;

        req_ready_o = (state_q == IDLE);
        busy_o      = (state_q != IDLE);
        rsp_valid_o = (state_q == BURST) || (state_q == WACK);
        rsp_last_o  = ((state_q == BURST) && (beat_q == LAST_BEAT)) || (state_q == WACK);
        rsp_data_o  = (state_q == BURST) ? ram_rdata : '0;
        rsp_hs      = rsp_valid_o && rsp_ready_i;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    write_d = req_write_i;
                    beat_d  = '0;
                    if (LAT == 4'd0) begin
                        lat_d   = 4'd0;
                        state_d = req_write_i ? WACK : BURST;
                        ram_we  = req_write_i;
                    end else begin
                        lat_d   = LAT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (lat_q <= 4'd1) begin
                    lat_d   = 4'd0;
                    state_d = write_q ? WACK : BURST;
                    ram_we  = write_q;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            BURST: begin
                if (rsp_hs) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            WACK: begin
                if (rsp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lat_q   <= 4'd0;
            beat_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    // A reset on the commit edge suppresses the write.
    refill_ram #(
        .DW (DW),
        .AW (MEM_AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we & ~rst),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

endmodule
